alu_arbiter: RTL and testbench

//   Shares the single combinational ALU (rs1, rs2, sel -> sal) between two requesters.

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_rr.sv | 22 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding, width defaults, ALU op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SEL_W = 3;

    // Arbiter sequencing: wait for a request, let the ALU settle, present the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation codes understood by the shared ALU instance
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL = 3'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL = 3'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to whoever did not win last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is actually taken.
module rr_arbiter_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    // Tie broken against the previous winner; otherwise the only requester wins
    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one operation in flight.
// Latency: accept at edge T -> resp_valid after edge T+EXEC_CYCLES; accepts spaced EXEC_CYCLES+2.
// Backpressure: resp_sal/resp_id hold while resp_ready=0; no request is accepted until the result drains.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH       = ALU_WIDTH,
    parameter int SEL_W       = ALU_SEL_W,
    // Settle time of the ALU in cycles; the counter below is 4 bits, so 1..15
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [SEL_W-1:0] req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [SEL_W-1:0] req1_sel,

    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_sal,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sal
);

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       gnt_valid;
    logic       gnt_id;
    logic       accept;

    rr_arbiter_2 u_rr (
        .req0       (req0_valid),
        .req1       (req1_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Ready only in IDLE, so a handshake can only happen when nothing is in flight
    always_comb begin
        req0_ready = (state == IDLE) && gnt_valid && !gnt_id;
        req1_ready = (state == IDLE) && gnt_valid &&  gnt_id;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Sequencer: latch operands on accept, sample the ALU after the settle time, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_sel    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_sal   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // gnt_id names the winner; its operands are captured and held for the ALU
                        alu_rs1    <= gnt_id ? req1_rs1 : req0_rs1;
                        alu_rs2    <= gnt_id ? req1_rs2 : req0_rs2;
                        alu_sel    <= gnt_id ? req1_sel : req0_sel;
                        resp_id    <= gnt_id;
                        last_grant <= gnt_id;
                        cnt        <= 4'd1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == EXEC_LAST) begin
                        resp_sal   <= alu_sal;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: randomized resp_ready in the random phase.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    // Instance with a one-cycle ALU
    logic          v0, v1, r0, r1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [SW-1:0] s0, s1;
    logic [W-1:0]  alu_rs1, alu_rs2, alu_sal, resp_sal;
    logic [SW-1:0] alu_sel;
    logic          resp_valid, resp_ready, resp_id;

    // Instance with a four-cycle ALU
    logic          q_v0, q_v1, q_r0, q_r1;
    logic [W-1:0]  q_a0, q_b0, q_a1, q_b1;
    logic [SW-1:0] q_s0, q_s1;
    logic [W-1:0]  q_alu_rs1, q_alu_rs2, q_alu_sal, q_resp_sal;
    logic [SW-1:0] q_alu_sel;
    logic          q_resp_valid, q_resp_ready, q_resp_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stub ALU: adder, ignores the op select
    assign alu_sal   = alu_rs1 + alu_rs2;
    assign q_alu_sal = q_alu_rs1 + q_alu_rs2;

    alu_arbiter #(.WIDTH(W), .SEL_W(SW), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_rs1(a0), .req0_rs2(b0), .req0_sel(s0),
        .req1_valid(v1), .req1_ready(r1), .req1_rs1(a1), .req1_rs2(b1), .req1_sel(s1),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_sel(alu_sel), .alu_sal(alu_sal),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_sal(resp_sal)
    );

    alu_arbiter #(.WIDTH(W), .SEL_W(SW), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(q_v0), .req0_ready(q_r0), .req0_rs1(q_a0), .req0_rs2(q_b0), .req0_sel(q_s0),
        .req1_valid(q_v1), .req1_ready(q_r1), .req1_rs1(q_a1), .req1_rs2(q_b1), .req1_sel(q_s1),
        .alu_rs1(q_alu_rs1), .alu_rs2(q_alu_rs2), .alu_sel(q_alu_sel), .alu_sal(q_alu_sal),
        .resp_valid(q_resp_valid), .resp_ready(q_resp_ready), .resp_id(q_resp_id), .resp_sal(q_resp_sal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 0; v1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; s0 = '0; s1 = '0;
        resp_ready = 1;
        q_v0 = 0; q_v1 = 0; q_a0 = '0; q_b0 = '0; q_a1 = '0; q_b1 = '0; q_s0 = '0; q_s1 = '0;
        q_resp_ready = 1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        checks++;
        if ({r0, r1} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {r0, r1}); end
        checks++;
        if (alu_rs1 !== 0 || alu_rs2 !== 0 || alu_sel !== 0) begin
            errors++; $display("FAIL reset_alu: got %0d %0d %0d want 0 0 0", alu_rs1, alu_rs2, alu_sel);
        end
        checks++;
        if (resp_valid !== 0 || resp_sal !== 0 || resp_id !== 0) begin
            errors++; $display("FAIL reset_resp: got v=%b sal=%0d id=%b want 0", resp_valid, resp_sal, resp_id);
        end
        rst = 0;
        tick();
        checks++;
        if (resp_valid !== 0 || r0 !== 0 || r1 !== 0 || q_resp_valid !== 0) begin
            errors++; $display("FAIL reset_release: got v=%b r=%b%b qv=%b want 0", resp_valid, r0, r1, q_resp_valid);
        end
    endtask

    task automatic test_single();
        reset_dut();
        v0 = 1; a0 = 226; b0 = 7; s0 = 0;
        #1;
        checks++;
        if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {r0, r1}); end
        tick();                     // edge T: accepted
        v0 = 1; a0 = 999; b0 = 999; // stays valid but must not be granted while busy
        #1;
        checks++;
        if (r0 !== 0 || resp_valid !== 0 || alu_rs1 !== 226 || alu_rs2 !== 7) begin
            errors++; $display("FAIL single_exec: got r0=%b v=%b rs1=%0d rs2=%0d want 0 0 226 7", r0, resp_valid, alu_rs1, alu_rs2);
        end
        v0 = 0;
        tick();                     // edge T+1
        checks++;
        if (resp_valid !== 1 || resp_sal !== 233 || resp_id !== 0) begin
            errors++; $display("FAIL single_resp: got v=%b sal=%0d id=%b want 1 233 0", resp_valid, resp_sal, resp_id);
        end
        tick();                     // edge T+2: consumed
        v1 = 1;
        #1;
        checks++;
        if (resp_valid !== 0 || r1 !== 1) begin
            errors++; $display("FAIL single_idle: got v=%b r1=%b want 0 1", resp_valid, r1);
        end
        v1 = 0;
        #1;
    endtask

    task automatic test_alternate();
        int acc_cyc[$];
        int acc_id[$];
        logic [W-1:0] exp_sal[$];
        int nresp;
        reset_dut();
        nresp = 0;
        v0 = 1; v1 = 1; resp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            a0 = W'(c); b0 = 100; a1 = W'(c); b1 = 200;
            #1;
            if (resp_valid === 1) begin
                checks++;
                if (exp_sal.size() == 0 || resp_id !== nresp[0] || resp_sal !== exp_sal[0]) begin
                    errors++; $display("FAIL alt_resp%0d: got id=%b sal=%0d want id=%0d", nresp, resp_id, resp_sal, nresp % 2);
                end
                if (exp_sal.size() != 0) void'(exp_sal.pop_front());
                nresp++;
            end
            if (r0 === 1 || r1 === 1) begin
                acc_cyc.push_back(c);
                acc_id.push_back(r1 ? 1 : 0);
                exp_sal.push_back(W'(c) + ((acc_id.size() % 2 == 0) ? 200 : 100));
            end
            tick();
        end
        v0 = 0; v1 = 0;
        checks++;
        if (acc_cyc.size() != 4 || nresp != 4) begin
            errors++; $display("FAIL alt_count: got accepts=%0d resps=%0d want 4 4", acc_cyc.size(), nresp);
        end
        for (int k = 0; k < acc_cyc.size(); k++) begin
            checks++;
            if (acc_id[k] != k % 2 || acc_cyc[k] != 3 * k) begin
                errors++; $display("FAIL alt_grant%0d: got id=%0d cyc=%0d want id=%0d cyc=%0d", k, acc_id[k], acc_cyc[k], k % 2, 3 * k);
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        v0 = 1; a0 = 5; b0 = 6; s0 = 3; resp_ready = 0;
        tick();
        v0 = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            v0 = 1; v1 = 1; a0 = W'(40 + i); a1 = W'(80 + i);
            #1;
            checks++;
            if (resp_valid !== 1 || resp_sal !== 11 || resp_id !== 0 || r0 !== 0 || r1 !== 0 || alu_rs1 !== 5 || alu_sel !== 3) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b sal=%0d id=%b r=%b%b rs1=%0d want 1 11 0 00 5", i, resp_valid, resp_sal, resp_id, r0, r1, alu_rs1);
            end
            tick();
        end
        v0 = 0; v1 = 0; resp_ready = 1;
        tick();
        checks++;
        if (resp_valid !== 0) begin errors++; $display("FAIL bp_drain: got v=%b want 0", resp_valid); end
    endtask

    task automatic test_exec4();
        reset_dut();
        q_v1 = 1; q_a1 = 100; q_b1 = 28; q_s1 = 2;
        #1;
        checks++;
        if ({q_r0, q_r1} !== 2'b01) begin errors++; $display("FAIL ex4_ready: got %b want 01", {q_r0, q_r1}); end
        tick();                     // edge T
        q_v1 = 0; q_a1 = 0; q_b1 = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_alu_rs1 !== 100 || q_alu_rs2 !== 28 || q_alu_sel !== 2 || q_resp_valid !== 0) begin
                errors++; $display("FAIL ex4_hold%0d: got rs1=%0d rs2=%0d v=%b want 100 28 0", i, q_alu_rs1, q_alu_rs2, q_resp_valid);
            end
            tick();
        end
        checks++;                   // after edge T+4
        if (q_resp_valid !== 1 || q_resp_sal !== 128 || q_resp_id !== 1) begin
            errors++; $display("FAIL ex4_resp: got v=%b sal=%0d id=%b want 1 128 1", q_resp_valid, q_resp_sal, q_resp_id);
        end
        tick();
        checks++;
        if (q_resp_valid !== 0) begin errors++; $display("FAIL ex4_drain: got v=%b want 0", q_resp_valid); end
    endtask

    task automatic test_reset_mid();
        int seen;
        reset_dut();
        v1 = 1; a1 = 50; b1 = 60;
        tick();                     // requester 1 accepted alone
        v1 = 0;
        #2;
        rst = 1;                    // asynchronous, mid-EXEC
        #2;
        rst = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid === 1) seen++;
        end
        checks++;
        if (seen != 0 || alu_rs1 !== 0) begin errors++; $display("FAIL mid_discard: got resp_cycles=%0d rs1=%0d want 0 0", seen, alu_rs1); end
        v0 = 1; a0 = 1; b0 = 2; v1 = 1; a1 = 7; b1 = 7;
        #1;
        checks++;
        if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL mid_prio: got %b want 10", {r0, r1}); end
        tick();
        v0 = 0; v1 = 0;
        tick();
        checks++;
        if (resp_valid !== 1 || resp_sal !== 3 || resp_id !== 0) begin
            errors++; $display("FAIL mid_resp: got v=%b sal=%0d id=%b want 1 3 0", resp_valid, resp_sal, resp_id);
        end
        tick();
    endtask

    // Transaction model: one outstanding op; result visible EXEC cycles after accept; freed when taken
    task automatic test_random();
        bit           m_out, m_vis, m_last, m_id, e0, e1;
        int           m_k;
        logic [W-1:0] m_sal, m_rs1, m_rs2;
        logic [SW-1:0] m_sel;
        int           nacc;
        reset_dut();
        m_out = 0; m_vis = 0; m_last = 1; m_id = 0; m_k = 0;
        m_sal = '0; m_rs1 = '0; m_rs2 = '0; m_sel = '0; nacc = 0;
        for (int c = 0; c < 400; c++) begin
            v0 = ($urandom_range(0, 99) < 60);
            v1 = ($urandom_range(0, 99) < 60);
            a0 = $urandom; b0 = $urandom; s0 = SW'($urandom);
            a1 = $urandom; b1 = $urandom; s1 = SW'($urandom);
            resp_ready = ($urandom_range(0, 99) < 65);
            #1;
            e0 = !m_out && v0 && (!v1 || m_last == 1);
            e1 = !m_out && v1 && (!v0 || m_last == 0);
            checks++;
            if (r0 !== e0 || r1 !== e1 || resp_valid !== m_vis) begin
                errors++; $display("FAIL rnd_hs c=%0d: got r=%b%b v=%b want r=%b%b v=%b", c, r0, r1, resp_valid, e0, e1, m_vis);
            end
            if (m_vis) begin
                checks++;
                if (resp_sal !== m_sal || resp_id !== m_id) begin
                    errors++; $display("FAIL rnd_resp c=%0d: got sal=%0h id=%b want %0h %b", c, resp_sal, resp_id, m_sal, m_id);
                end
            end
            if (m_out) begin
                checks++;
                if (alu_rs1 !== m_rs1 || alu_rs2 !== m_rs2 || alu_sel !== m_sel) begin
                    errors++; $display("FAIL rnd_alu c=%0d: got %0h %0h %0d want %0h %0h %0d", c, alu_rs1, alu_rs2, alu_sel, m_rs1, m_rs2, m_sel);
                end
            end
            if (m_vis && resp_ready) begin
                m_out = 0; m_vis = 0;
            end else if (m_out && !m_vis) begin
                m_k--;
                if (m_k == 0) m_vis = 1;
            end
            if (e0 || e1) begin
                m_out = 1; m_k = 1; m_id = e1; m_last = e1; nacc++;
                m_rs1 = e1 ? a1 : a0; m_rs2 = e1 ? b1 : b0; m_sel = e1 ? s1 : s0;
                m_sal = m_rs1 + m_rs2;
            end
            tick();
        end
        checks++;
        if (nacc < 20) begin errors++; $display("FAIL rnd_activity: got accepts=%0d want >=20", nacc); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_exec4();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
